// File: rtl/asteroid_target.sv
`default_nettype none
// ============================================================================
//  Module   : asteroid_target
//  Purpose  : Falling target that counts bullet hits, explodes, respawns and
//             reports escapes. Optional sideways drift: ASTEROID_DRIFT_EN.
//  Revision : 1.0
// ============================================================================
module asteroid_target #(
    parameter int Y_TOP          = 20,
    parameter int Y_BOTTOM       = 460,
    parameter int X_MIN          = 40,
    parameter int X_MAX          = 600,
    parameter int X_START        = 320,
    parameter int HALF_SIZE      = 8,
    parameter int SPEED          = 1,
    parameter int HP             = 2,
    parameter int EXPLODE_FRAMES = 16,
    parameter int RESPAWN_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pixpulse,
    input  logic [9:0] hcount,
    input  logic [9:0] vcount,
    input  logic       move,
    input  logic       bullet_px,
    output logic       draw_asteroid,
    output logic [9:0] xloc,
    output logic [9:0] yloc,
    output logic       active,
    output logic       destroyed,
    output logic       escaped
);

    localparam int WW     = $clog2(RESPAWN_FRAMES + 1);
    localparam int EW_RAW = $clog2(EXPLODE_FRAMES + 1);
    localparam int EW     = (EW_RAW < 2) ? 2 : EW_RAW;

    localparam logic [9:0]    Y_TOP_V    = 10'(Y_TOP);
    localparam logic [9:0]    Y_BOTTOM_V = 10'(Y_BOTTOM);
    localparam logic [9:0]    X_MIN_V    = 10'(X_MIN);
    localparam logic [9:0]    X_MAX_V    = 10'(X_MAX);
    localparam logic [9:0]    X_START_V  = 10'(X_START);
    localparam logic [9:0]    SPEED_V    = 10'(SPEED);
    localparam logic [10:0]   HALF_V     = 11'(HALF_SIZE);
    localparam logic [2:0]    HP_V       = 3'(HP);
    localparam logic [WW-1:0] WAIT_V     = WW'(RESPAWN_FRAMES);
    localparam logic [EW-1:0] EXP_V      = EW'(EXPLODE_FRAMES);

    typedef enum logic [1:0] {
        S_WAIT    = 2'd0,
        S_FALL    = 2'd1,
        S_EXPLODE = 2'd2
    } state_t;

    state_t        state, state_nx;
    logic [WW-1:0] wait_cnt, wait_nx;
    logic [EW-1:0] exp_cnt, exp_nx;
    logic [2:0]    hp, hp_nx;
    logic [9:0]    x_nx, y_nx;
    logic          hit_flag, hit_nx;
    logic          destroyed_nx, escaped_nx;
    logic [9:0]    lfsr;
    logic          inbox;
    logic [9:0]    spawn_sum, spawn_x, y_desc;
`ifdef ASTEROID_DRIFT_EN
    logic          dir, dir_nx;
    logic [9:0]    x_step;
`endif

    // Compares are done in 11 bits so the box edges never wrap near zero.
    assign inbox = ({1'b0, hcount} + HALF_V >= {1'b0, xloc}) &&
                   ({1'b0, hcount} <= {1'b0, xloc} + HALF_V) &&
                   ({1'b0, vcount} + HALF_V >= {1'b0, yloc}) &&
                   ({1'b0, vcount} <= {1'b0, yloc} + HALF_V);

    assign spawn_sum = X_MIN_V + {1'b0, lfsr[8:0]};
    assign spawn_x   = (spawn_sum > X_MAX_V) ? X_MAX_V : spawn_sum;
    assign y_desc    = yloc + SPEED_V;

    assign active        = (state == S_FALL);
    assign draw_asteroid = inbox && ((state == S_FALL) ||
                                     ((state == S_EXPLODE) && exp_cnt[1]));

    always_comb begin
        state_nx     = state;
        wait_nx      = wait_cnt;
        exp_nx       = exp_cnt;
        hp_nx        = hp;
        x_nx         = xloc;
        y_nx         = yloc;
        hit_nx       = hit_flag;
        destroyed_nx = destroyed;
        escaped_nx   = escaped;
`ifdef ASTEROID_DRIFT_EN
        dir_nx       = dir;
        x_step       = dir ? (xloc + 10'd1) : (xloc - 10'd1);
`endif
        if (pixpulse) begin
            destroyed_nx = 1'b0;
            escaped_nx   = 1'b0;
            if (!move) begin
                if ((state == S_FALL) && inbox && bullet_px)
                    hit_nx = 1'b1;
            end else begin
                hit_nx = 1'b0;
                case (state)
                    S_WAIT: begin
                        if (wait_cnt <= WW'(1)) begin
                            wait_nx  = '0;
                            x_nx     = spawn_x;
                            y_nx     = Y_TOP_V;
                            hp_nx    = HP_V;
                            state_nx = S_FALL;
`ifdef ASTEROID_DRIFT_EN
                            dir_nx   = lfsr[9];
`endif
                        end else begin
                            wait_nx = wait_cnt - WW'(1);
                        end
                    end
                    S_FALL: begin
                        // A hit pre-empts descent, so a kill on the last row
                        // never also reports an escape.
                        if (hit_flag) begin
                            hp_nx = hp - 3'd1;
                            if (hp <= 3'd1) begin
                                hp_nx        = '0;
                                destroyed_nx = 1'b1;
                                exp_nx       = EXP_V;
                                state_nx     = S_EXPLODE;
                            end
                        end else begin
                            y_nx = y_desc;
`ifdef ASTEROID_DRIFT_EN
                            if (dir ? (x_step > X_MAX_V) : (x_step < X_MIN_V))
                                dir_nx = ~dir;
                            else
                                x_nx = x_step;
`endif
                            if (y_desc >= Y_BOTTOM_V) begin
                                escaped_nx = 1'b1;
                                wait_nx    = WAIT_V;
                                state_nx   = S_WAIT;
                            end
                        end
                    end
                    S_EXPLODE: begin
                        if (exp_cnt <= EW'(1)) begin
                            exp_nx   = '0;
                            wait_nx  = WAIT_V;
                            state_nx = S_WAIT;
                        end else begin
                            exp_nx = exp_cnt - EW'(1);
                        end
                    end
                    default: state_nx = S_WAIT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_WAIT;
            wait_cnt  <= WAIT_V;
            exp_cnt   <= '0;
            hp        <= HP_V;
            xloc      <= X_START_V;
            yloc      <= Y_TOP_V;
            hit_flag  <= 1'b0;
            destroyed <= 1'b0;
            escaped   <= 1'b0;
            lfsr      <= 10'h2A5;
`ifdef ASTEROID_DRIFT_EN
            dir       <= 1'b0;
`endif
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            exp_cnt   <= exp_nx;
            hp        <= hp_nx;
            xloc      <= x_nx;
            yloc      <= y_nx;
            hit_flag  <= hit_nx;
            destroyed <= destroyed_nx;
            escaped   <= escaped_nx;
            lfsr      <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
`ifdef ASTEROID_DRIFT_EN
            dir       <= dir_nx;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_asteroid_target.sv
`default_nettype none
// ============================================================================
//  Module   : tb_asteroid_target
//  Purpose  : Directed bench for asteroid_target with a per-cycle reference
//             model and hand-computed literal checkpoints.
//  Revision : 1.0
// ============================================================================
module tb_asteroid_target;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       pixpulse = 1'b0;
    logic       move = 1'b0;
    logic       bullet_px = 1'b0;
    logic [9:0] hcount = '0;
    logic [9:0] vcount = '0;
    logic       draw_asteroid, active, destroyed, escaped;
    logic [9:0] xloc, yloc;

    int tests = 0;
    int fails = 0;
    bit started = 0;
    int pdiv = 0;

    asteroid_target dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pixpulse      (pixpulse),
        .hcount        (hcount),
        .vcount        (vcount),
        .move          (move),
        .bullet_px     (bullet_px),
        .draw_asteroid (draw_asteroid),
        .xloc          (xloc),
        .yloc          (yloc),
        .active        (active),
        .destroyed     (destroyed),
        .escaped       (escaped)
    );

    always #5 clk = ~clk;

    // Pixel enable every fourth clock, changed 2 ns after the edge.
    always @(posedge clk) begin
        #2;
        pdiv = (pdiv + 1) % 4;
        pixpulse = (pdiv == 0);
    end

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // phase: 0 = waiting, 1 = falling, 2 = exploding
    int m_st = 0, m_x = 320, m_y = 20, m_hp = 2, m_wait = 30, m_exp = 0;
    int m_lfsr = 'h2A5;
    bit m_hit = 0, m_des = 0, m_esc = 0, m_dir = 0;

    function automatic bit m_inbox(input int h, input int v);
        return (h >= m_x - 8) && (h <= m_x + 8) && (v >= m_y - 8) && (v <= m_y + 8);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = 0; m_x = 320; m_y = 20; m_hp = 2; m_wait = 30; m_exp = 0;
            m_lfsr = 'h2A5; m_hit = 0; m_des = 0; m_esc = 0; m_dir = 0;
        end else begin
            if (pixpulse) begin
                m_des = 0;
                m_esc = 0;
                if (move) begin
                    if (m_st == 0) begin
                        m_wait = m_wait - 1;
                        if (m_wait == 0) begin
                            m_x = 40 + (m_lfsr % 512);
                            if (m_x > 600) m_x = 600;
                            m_y = 20;
                            m_hp = 2;
                            m_dir = (m_lfsr >> 9) & 1;
                            m_st = 1;
                        end
                    end else if (m_st == 1) begin
                        if (m_hit) begin
                            m_hp = m_hp - 1;
                            if (m_hp == 0) begin
                                m_des = 1; m_exp = 16; m_st = 2;
                            end
                        end else begin
                            m_y = m_y + 1;
`ifdef ASTEROID_DRIFT_EN
                            if (m_dir && m_x + 1 > 600) m_dir = 0;
                            else if (!m_dir && m_x - 1 < 40) m_dir = 1;
                            else m_x = m_dir ? m_x + 1 : m_x - 1;
`endif
                            if (m_y >= 460) begin
                                m_esc = 1; m_wait = 30; m_st = 0;
                            end
                        end
                    end else begin
                        m_exp = m_exp - 1;
                        if (m_exp == 0) begin
                            m_wait = 30; m_st = 0;
                        end
                    end
                    m_hit = 0;
                end else if (m_st == 1 && bullet_px && m_inbox(hcount, vcount)) begin
                    m_hit = 1;
                end
            end
            m_lfsr = ((m_lfsr * 2) % 1024) | (((m_lfsr >> 9) ^ (m_lfsr >> 6)) & 1);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("xloc", xloc, m_x);
            chk("yloc", yloc, m_y);
            chk("active", active, (m_st == 1));
            chk("destroyed", destroyed, m_des);
            chk("escaped", escaped, m_esc);
            chk("draw", draw_asteroid,
                m_inbox(hcount, vcount) && (m_st == 1 || (m_st == 2 && ((m_exp >> 1) & 1))));
        end
    end

    // ---------------- stimulus helpers (entered at edge + 3 ns) ----------------
    task automatic wait_pix();
        while (!pixpulse) begin
            @(posedge clk); #3;
        end
    endtask

    task automatic do_move();
        wait_pix();
        move = 1'b1;
        @(posedge clk); #3;
        move = 1'b0;
    endtask

    task automatic moves(input int n);
        for (int i = 0; i < n; i++) do_move();
    endtask

    task automatic fire();
        wait_pix();
        bullet_px = 1'b1;
        @(posedge clk); #3;
        bullet_px = 1'b0;
    endtask

    task automatic aim(input int dx, input int dy);
        hcount = 10'(m_x + dx);
        vcount = 10'(m_y + dy);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: got no finish expected finish");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

    initial begin
        #1 rst_n = 1'b0;
        started = 1;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;

        chk("rst_xloc", xloc, 320);
        chk("rst_yloc", yloc, 20);
        chk("rst_active", active, 0);
        hcount = 10'd320; vcount = 10'd20; #1;
        chk("rst_draw", draw_asteroid, 0);

        moves(29);
        chk("wait29_active", active, 0);
        do_move();
        chk("spawn_active", active, 1);
        chk("spawn_y", yloc, 20);
        chk("spawn_x_range", int'(xloc >= 40 && xloc <= 600), 1);

        moves(80);
        chk("fall_y100", yloc, 100);
        do_move();
        chk("fall_y101", yloc, 101);
        chk("fall_destroyed", destroyed, 0);
        chk("fall_escaped", escaped, 0);

        aim(8, -8);  chk("edge_tr", draw_asteroid, 1);
        aim(9, 0);   chk("out_r", draw_asteroid, 0);
        aim(-8, 8);  chk("edge_bl", draw_asteroid, 1);
        aim(0, 9);   chk("out_b", draw_asteroid, 0);
        aim(-9, 0);  chk("out_l", draw_asteroid, 0);

        aim(0, 0);
        fire();
        do_move();
        chk("pause_y", yloc, 101);
        chk("pause_active", active, 1);
        fire();
        do_move();
        chk("kill_destroyed", destroyed, 1);
        chk("kill_active", active, 0);
        chk("kill_y", yloc, 101);
        #1 chk("explode16_draw", draw_asteroid, 0);
        do_move();
        #1 chk("explode15_draw", draw_asteroid, 1);
        fire();
        moves(14);
        chk("explode_frozen_y", yloc, 101);
        do_move();
        #1 chk("wait_draw", draw_asteroid, 0);
        chk("wait_active", active, 0);

        moves(30);
        chk("respawn_active", active, 1);
        moves(439);
        chk("pre_escape_y", yloc, 459);
        do_move();
        chk("escape_y", yloc, 460);
        chk("escape_pulse", escaped, 1);
        chk("escape_active", active, 0);

        moves(30);
        chk("respawn2_active", active, 1);
        moves(280);
        aim(0, 0);
        fire();
        do_move();
        chk("pause300_y", yloc, 300);
        moves(159);
        chk("last_row_y", yloc, 459);
        aim(0, 0);
        fire();
        do_move();
        chk("tie_destroyed", destroyed, 1);
        chk("tie_escaped", escaped, 0);
        chk("tie_y", yloc, 459);

        moves(3);
        rst_n = 1'b0;
        aim(0, 0);
        chk("midrst_xloc", xloc, 320);
        chk("midrst_yloc", yloc, 20);
        chk("midrst_draw", draw_asteroid, 0);
        chk("midrst_active", active, 0);
        chk("midrst_destroyed", destroyed, 0);
        chk("midrst_escaped", escaped, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        moves(2);
        chk("post_rst_active", active, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
